// File: rtl/vga_blank_arbiter.sv
`timescale 1ns/1ps
// Purpose : round-robin share of one framebuffer write port among NREQ engines, open only during vertical blank.
// Latency : req->gnt 1 cycle from ARB (2 from IDLE when the window opens); gnt+wr_en_in -> mem_* 1 cycle.
// Backpr. : none on the memory side; engines wait on gnt, and lose the port on release, MAX_GRANT expiry or window close (abort).
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   vcount, vblnk   line counter and vertical blank from vga_timing
//   req             per-engine request level, held for the whole burst
//   wr_en_in        per-engine write strobe, honoured only for the current owner
//   addr_in/data_in packed per-engine address/pixel, engine i at [i*W +: W]
//   gnt             registered one-hot-or-zero grant
//   abort           one-cycle pulse to an owner cut off by window close
//   mem_we/addr/data registered framebuffer write port
//   frame_tick      one-cycle pulse one cycle after vblnk rises
module vga_blank_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 12,
  parameter int MAX_GRANT   = 256,
  parameter int VER_TOT     = 628,
  parameter int GUARD_LINES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              vcount,
  input  logic                     vblnk,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr_en_in,
  input  logic [NREQ*ADDR_W-1:0]   addr_in,
  input  logic [NREQ*DATA_W-1:0]   data_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          abort,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic                     frame_tick
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_GRANT);
  localparam logic [10:0]      WIN_END  = 11'(VER_TOT - GUARD_LINES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GRANT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] own, own_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [NREQ-1:0]  gnt_nxt, abort_nxt;
  logic             vblnk_q;
  logic             win;
  logic             found;
  logic [PTR_W-1:0] win_idx;
  logic             we;

  // Guard lines at the end of blank keep writes clear of the frame wrap.
  assign win = vblnk && (vcount < WIN_END);

  // Priority search starting at ptr, wrapping upward.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    abort_nxt = '0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (win) state_nxt = ARB;
      end
      ARB: begin
        gnt_nxt = '0;
        if (!win) begin
          state_nxt = IDLE;
        end else if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = GNT_ONE << win_idx;
          own_nxt   = win_idx;
          cnt_nxt   = '0;
          ptr_nxt   = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 1'b1;
        // Window close outranks release and expiry; release and expiry
        // together are just a release (same outcome, no abort).
        if (!win) begin
          state_nxt      = IDLE;
          gnt_nxt        = '0;
          abort_nxt[own] = 1'b1;
        end else if (!req[own] || (cnt == CNT_LAST)) begin
          state_nxt = ARB;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      abort <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      abort <= abort_nxt;
    end
  end

  // gnt is zero outside GRANT, so own only matters when we is set.
  assign we = |(gnt & wr_en_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      mem_we     <= we;
      vblnk_q    <= vblnk;
      frame_tick <= vblnk & ~vblnk_q;
      if (we) begin
        mem_addr <= addr_in[int'(own)*ADDR_W +: ADDR_W];
        mem_data <= data_in[int'(own)*DATA_W +: DATA_W];
      end
    end
  end

endmodule
